// File: rtl/mc_datapath.sv
// Multicycle RV32I core datapath sharing one memory port for fetch and LW/SW.
// Define MC_RETIRE_COUNTER_EN to build the retired-instruction counter; otherwise retired reads 0.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       pc_out,
  output logic [2:0]        state_out,
  output logic [31:0]       retired
);
  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } state_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t             state, state_nxt;
  logic [31:0]        pc, ir;
  logic [31:0]        rf [32];
  logic [WAIT_W-1:0]  wait_cnt;
  logic signed [31:0] rs1_v, rs2_v, imm, imm_dec, opb;
  logic [31:0]        pc4, alu, alu_res, ld_data, wb_data;
  logic [4:0]         opc, rd;
  logic [2:0]         f3;
  logic               illegal, stop, taken, timeout_hit, is_jump;

  assign opc     = ir[6:2];
  assign rd      = ir[11:7];
  assign f3      = ir[14:12];
  assign is_jump = (opc == OPC_JAL) || (opc == OPC_JALR);

  always_comb begin
    case (opc)
      OPC_LOAD, OPC_MISC, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: illegal = (ir[1:0] != 2'b11);
      default: illegal = 1'b1;
    endcase
  end
  assign stop = !illegal && ((opc == OPC_SYSTEM) || (opc == OPC_MISC));

  always_comb begin
    imm_dec = {{20{ir[31]}}, ir[31:20]};
    case (opc)
      OPC_STORE:          imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:         imm_dec = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm_dec = {ir[31:12], 12'd0};
      OPC_JAL:            imm_dec = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      default: ;
    endcase
  end

  // EXECUTE: operands come from the registers latched in DECODE
  assign opb = (opc == OPC_OP) ? rs2_v : imm;
  always_comb begin
    alu_res = rs1_v + opb;
    case (opc)
      OPC_LUI:            alu_res = imm;
      OPC_AUIPC, OPC_JAL: alu_res = pc + imm;
      OPC_JALR:           alu_res = (rs1_v + imm) & ~32'd1;
      OPC_OP, OPC_OPIMM: begin
        case (f3)
          3'b000:  alu_res = (opc == OPC_OP && ir[30]) ? rs1_v - opb : rs1_v + opb;
          3'b001:  alu_res = rs1_v << opb[4:0];
          3'b010:  alu_res = {31'd0, rs1_v < opb};
          3'b011:  alu_res = {31'd0, $unsigned(rs1_v) < $unsigned(opb)};
          3'b100:  alu_res = rs1_v ^ opb;
          3'b101:  alu_res = ir[30] ? rs1_v >>> opb[4:0] : rs1_v >> opb[4:0];
          3'b110:  alu_res = rs1_v | opb;
          default: alu_res = rs1_v & opb;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  taken = (rs1_v == rs2_v);
      3'b001:  taken = (rs1_v != rs2_v);
      3'b100:  taken = (rs1_v < rs2_v);
      3'b101:  taken = (rs1_v >= rs2_v);
      3'b110:  taken = ($unsigned(rs1_v) < $unsigned(rs2_v));
      3'b111:  taken = ($unsigned(rs1_v) >= $unsigned(rs2_v));
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    if (is_jump)               wb_data = pc4;
    else if (opc == OPC_LOAD)  wb_data = ld_data;
    else if (opc == OPC_LUI)   wb_data = imm;
    else                       wb_data = alu;
  end

  assign mem_req     = (state == FETCH) || (state == MEM);
  assign mem_we      = (state == MEM) && (opc == OPC_STORE);
  assign mem_addr    = (state == MEM) ? {alu[ADDR_W-1:2], 2'b00} : {pc[ADDR_W-1:2], 2'b00};
  assign mem_wdata   = rs2_v;
  assign timeout_hit = (TIMEOUT > 0) && mem_req && !mem_ready
                       && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign halted      = (state == HALT);
  assign pc_out      = pc;
  assign state_out   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (mem_ready) state_nxt = DECODE;
               else if (timeout_hit) state_nxt = HALT;
      DECODE:  state_nxt = (illegal || stop) ? HALT : EXECUTE;
      EXECUTE: if (opc == OPC_LOAD || opc == OPC_STORE) state_nxt = MEM;
               else if (opc == OPC_BRANCH) state_nxt = FETCH;
               else state_nxt = WB;
      MEM:     if (mem_ready) state_nxt = (opc == OPC_STORE) ? FETCH : WB;
               else if (timeout_hit) state_nxt = HALT;
      WB:      state_nxt = FETCH;
      default: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) wait_cnt <= '0;
      else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      case (state)
        FETCH:   if (mem_ready) ir <= mem_rdata;
                 else if (timeout_hit) fault <= 1'b1;
        DECODE:  if (illegal) fault <= 1'b1;
        EXECUTE: if (opc == OPC_BRANCH) pc <= taken ? pc + imm : pc4;
        MEM:     if (mem_ready && opc == OPC_STORE) pc <= pc4;
                 else if (timeout_hit) fault <= 1'b1;
        WB:      pc <= is_jump ? alu : pc4;
        default: ;
      endcase
    end
  end

  // WB: register file write, x0 stays zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == WB && rd != 5'd0) begin
      rf[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (state == DECODE) begin
      rs1_v <= rf[ir[19:15]];
      rs2_v <= rf[ir[24:20]];
      imm   <= imm_dec;
      pc4   <= pc + 32'd4;
    end
    if (state == EXECUTE) alu <= alu_res;
    if (state == MEM && mem_ready) ld_data <= mem_rdata;
  end

`ifdef MC_RETIRE_COUNTER_EN
  logic [31:0] retire_cnt;
  logic        retire_now;
  assign retire_now = (state == WB)
                      || (state == MEM && mem_ready && opc == OPC_STORE)
                      || (state == EXECUTE && opc == OPC_BRANCH);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retire_cnt <= '0;
    else if (retire_now) retire_cnt <= retire_cnt + 32'd1;
  end
  assign retired = retire_cnt;
`else
  assign retired = 32'd0;
`endif

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL have parameter ADDR_W, default 8, the byte-address width driven on mem_addr (must be 3..32).
REQ-003 The block SHALL have parameter TIMEOUT, default 16, the maximum wait cycles for mem_ready; 0 disables the timeout.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port mem_req, output, 1 bit: unified memory access request.
REQ-007 The block SHALL have port mem_we, output, 1 bit: write strobe, valid with mem_req.
REQ-008 The block SHALL have port mem_addr, output, ADDR_W bits: byte address, bits [1:0] always 0.
REQ-009 The block SHALL have port mem_wdata, output, 32 bits: store data.
REQ-010 The block SHALL have port mem_rdata, input, 32 bits: read data, valid when mem_ready=1.
REQ-011 The block SHALL have port mem_ready, input, 1 bit: access accepted/completed this cycle.
REQ-012 The block SHALL have port halted, output, 1 bit: core stopped in HALT.
REQ-013 The block SHALL have port fault, output, 1 bit: halt cause was an illegal opcode or a memory timeout.
REQ-014 The block SHALL have port pc_out, output, 32 bits: current PC.
REQ-015 The block SHALL have port state_out, output, 3 bits: FSM state encoding.
REQ-016 The block SHALL have port retired, output, 32 bits: count of retired instructions.

Function
REQ-017 The FSM SHALL use states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5.
REQ-018 In FETCH, the block SHALL hold mem_req=1, mem_we=0 and mem_addr=PC[ADDR_W-1:0]; when mem_ready=1 it SHALL latch mem_rdata into IR and go to DECODE.
REQ-019 In DECODE, the block SHALL latch rs1, rs2, immediate and PC+4; SYSTEM (opcode[6:2]=11100) or MISC-MEM (00011) SHALL go to HALT with fault=0, and any opcode outside RV32I SHALL go to HALT with fault=1.
REQ-020 In EXECUTE, the block SHALL latch the ALU result: LW/SW SHALL go to MEM, and branches SHALL go to FETCH with PC=branch-taken ? PC+imm : PC+4.
REQ-021 In EXECUTE, all other instructions SHALL go to WB.
REQ-022 In MEM, the block SHALL assert mem_req with mem_addr=ALU result and mem_we=1 for SW (mem_wdata=rs2); when mem_ready=1, SW SHALL go to FETCH with PC+4 and LW SHALL latch mem_rdata and go to WB.
REQ-023 In WB, the block SHALL write rd with PC+4 (JAL/JALR), the load data (LW), the immediate (LUI) or the ALU result (others, including AUIPC); a write to x0 SHALL be discarded.
REQ-024 In WB, the block SHALL set PC to the jump target for JAL/JALR (JALR target bit 0 cleared) or PC+4 otherwise, then go to FETCH.
REQ-025 With mem_ready=1 on the request cycle, latency SHALL be: ALU/LUI/AUIPC/JAL/JALR 4 cycles, branch 3 cycles, SW 4 cycles, LW 5 cycles.
REQ-026 The wait counter SHALL clear on entry to FETCH/MEM; with TIMEOUT>0, TIMEOUT consecutive cycles of mem_req=1 and mem_ready=0 SHALL go to HALT with fault=1 and mem_req deasserted.
REQ-027 HALT SHALL be terminal until reset, with mem_req=0, no register writes and no PC change.
REQ-028 mem_req SHALL be 0 in DECODE, EXECUTE, WB and HALT.
REQ-029 The retire count SHALL increment by 1 when leaving WB, or when leaving MEM for SW, or when leaving EXECUTE for a branch, and SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-030 The block SHALL use asynchronous, active-high reset on reset: state=FETCH, PC=RESET_PC, IR=0, halted=0, fault=0, retired=0, mem_req asserts in the first cycle after release.
REQ-031 Reset asserted mid-access SHALL abandon the access immediately; the register file SHALL clear to 0.

Configuration
REQ-032 With macro MC_RETIRE_COUNTER_EN defined, retired SHALL behave per REQ-029; when undefined, retired SHALL be constant 0 and the counter logic SHALL be absent.

Verification
REQ-033 addi x1,x0,5 with zero-wait memory -> x1=5 after 4 cycles, PC=4, retired=1.
REQ-034 sw x1,8(x0) then lw x2,8(x0) with mem_ready delayed 2 cycles -> mem_we=1 with address 8 and data 5; x2=5; the LW takes 9 cycles.
REQ-035 beq x0,x0,+12 at PC=0x10 -> PC=0x1C after 3 cycles; bne x0,x0 -> PC=0x14.
REQ-036 jalr x1,4(x3) with x3=0x21 -> x1=PC+4, PC=0x24.
REQ-037 mem_ready held 0 with TIMEOUT=16 -> HALT after 16 request cycles, fault=1, mem_req=0.
REQ-038 ecall -> halted=1, fault=0, PC frozen; reset pulse -> state=FETCH, PC=RESET_PC.
